// File: rtl/binary_conv_mac.sv
// binary_conv_mac
//   Accumulates one binary-convolution window over BEATS input beats and
//   emits one signed partial sum per window. Each beat carries LANES binary
//   activations and LANES signed weights; a lane adds +w when its bit is 1
//   and -w when it is 0. The first beat of a window also folds in the
//   upstream psum and the bias.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   beat handshake (infmap_bits, weights, bias, inpsum)
//   out_valid/out_ready result handshake (outpsum, out_overflow)
//
// Build option
//   BINARY_CONV_MAC_SATURATE_EN : clamp the final value into the psum range
//                                 (default: two's-complement wrap).
//   out_overflow is reported in both builds.

// Per-lane signed contribution at accumulator width.
module binary_conv_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 18
) (
  input  logic                         i_bit,
  input  logic signed [DATA_WIDTH-1:0] i_weight,
  output logic signed [ACC_W-1:0]      o_term
);
  logic signed [ACC_W-1:0] w_wext;
  assign w_wext = ACC_W'(i_weight);
  assign o_term = i_bit ? w_wext : -w_wext;
endmodule

module binary_conv_mac #(
  parameter int DATA_WIDTH      = 8,
  parameter int PSUM_DATA_WIDTH = 12,
  parameter int LANES           = 3,
  parameter int BEATS           = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES-1:0]                  infmap_bits,
  input  logic [LANES*DATA_WIDTH-1:0]       weights,
  input  logic signed [DATA_WIDTH-1:0]      bias,
  input  logic signed [PSUM_DATA_WIDTH-1:0] inpsum,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [PSUM_DATA_WIDTH-1:0] outpsum,
  output logic                              out_overflow
);
  localparam int ACC_W = PSUM_DATA_WIDTH + $clog2(LANES*BEATS) + 2;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = PSUM_DATA_WIDTH;
  localparam logic signed [ACC_W-1:0] PMAX = {{(ACC_W-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] PMIN = {{(ACC_W-PW+1){1'b1}}, {(PW-1){1'b0}}};

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                  r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [PW-1:0]    r_outpsum;
  logic                    r_ovf;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;

  logic [LANES-1:0][ACC_W-1:0] w_terms;
  logic signed [ACC_W-1:0]     w_beat_term;
  logic signed [ACC_W-1:0]     w_base;
  logic signed [ACC_W-1:0]     w_final;
  logic signed [PW-1:0]        w_res;
  logic                        w_ovf;
  logic                        w_accept;
  logic                        w_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    binary_conv_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(ACC_W)) u_lane (
      .i_bit    (infmap_bits[g]),
      .i_weight (weights[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_term   (w_terms[g])
    );
  end

  always_comb begin
    w_beat_term = '0;
    for (int i = 0; i < LANES; i++) w_beat_term = w_beat_term + $signed(w_terms[i]);
  end

  // A first beat starts from upstream psum + bias instead of the accumulator,
  // which also covers BEATS==1 where every beat is both first and last.
  assign w_base  = (r_cnt == '0) ? (ACC_W'(inpsum) + ACC_W'(bias)) : r_acc;
  assign w_final = w_base + w_beat_term;
  assign w_ovf   = (w_final > PMAX) || (w_final < PMIN);

`ifdef BINARY_CONV_MAC_SATURATE_EN
  always_comb begin
    w_res = w_final[PW-1:0];
    if (w_final > PMAX)      w_res = PMAX[PW-1:0];
    else if (w_final < PMIN) w_res = PMIN[PW-1:0];
  end
`else
  assign w_res = w_final[PW-1:0];
`endif

  assign w_accept = in_valid && r_in_ready && (r_state == ACCUM);
  assign w_last   = (r_cnt == CNT_W'(BEATS-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ACCUM;
      r_in_ready  <= 1'b1;   // masked by reset below, so it reads 0 while reset is high
      r_out_valid <= 1'b0;
      r_outpsum   <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        ACCUM: if (w_accept) begin
          r_acc <= w_final;
          if (w_last) begin
            r_outpsum   <= w_res;
            r_ovf       <= w_ovf;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready     = r_in_ready && !reset;
  assign out_valid    = r_out_valid;
  assign outpsum      = r_outpsum;
  assign out_overflow = r_ovf;
endmodule

// File: tb/tb_binary_conv_mac.sv
module tb_binary_conv_mac;
  localparam int DW = 8, PW = 12, L = 3, B = 3;

  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_overflow;
  logic [L-1:0]           infmap_bits = '0;
  logic [L*DW-1:0]        weights = '0;
  logic signed [DW-1:0]   bias = '0;
  logic signed [PW-1:0]   inpsum = '0;
  logic signed [PW-1:0]   outpsum;

  int n_vec = 0, n_err = 0;
  logic [PW:0] sb_q[$];   // {overflow, psum}

  always #5 clk = ~clk;

  binary_conv_mac #(.DATA_WIDTH(DW), .PSUM_DATA_WIDTH(PW), .LANES(L), .BEATS(B)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .infmap_bits(infmap_bits), .weights(weights), .bias(bias), .inpsum(inpsum),
    .out_valid(out_valid), .out_ready(out_ready), .outpsum(outpsum),
    .out_overflow(out_overflow)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [PW:0] model(input logic [2:0] bits, input int w0, input int w1,
                                        input int w2, input int b, input int ip);
    int full, ps;
    int ws[3];
    logic ovf;
    ws = '{w0, w1, w2};
    full = ip + b;
    for (int i = 0; i < L; i++) full += B * (bits[i] ? ws[i] : -ws[i]);
    ovf = (full > 2047) || (full < -2048);
`ifdef BINARY_CONV_MAC_SATURATE_EN
    ps = (full > 2047) ? 2047 : (full < -2048) ? -2048 : full;
`else
    ps = full;
`endif
    return {ovf, ps[PW-1:0]};
  endfunction

  task automatic beat(input logic [2:0] bits, input int w0, input int w1, input int w2,
                      input int b, input int ip);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; infmap_bits = bits;
    weights = {8'(w2), 8'(w1), 8'(w0)}; bias = 8'(b); inpsum = 12'(ip);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) chk("beat_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic window(input string tag, input logic [2:0] bits, input int w0, input int w1,
                        input int w2, input int b, input int ip, input int gap);
    sb_q.push_back(model(bits, w0, w1, w2, b, ip));
    for (int k = 0; k < B; k++) begin
      beat(bits, w0, w1, w2, b, ip);
      if (k < B-1) begin
        repeat (gap) begin
          @(negedge clk);
          chk({tag, "_gap_novalid"}, 32'(out_valid), 32'd0);
        end
      end
    end
    @(negedge clk);
    chk({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic result(input string tag, input int hold);
    logic [PW:0] e;
    int t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    if (!out_valid) chk({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk({tag, "_psum"}, 32'(outpsum), 32'($signed(e[PW-1:0])));
    chk({tag, "_ovf"}, 32'(out_overflow), 32'(e[PW]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_psum"}, 32'(outpsum), 32'($signed(e[PW-1:0])));
      chk({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_inready"}, 32'(in_ready), 32'd1);
    chk({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_psum", 32'(outpsum), 32'd0);
    chk("rst_ovf", 32'(out_overflow), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_inready", 32'(in_ready), 32'd1);

    // all-ones window: 57
    window("ones", 3'b111, 5, 5, 5, 2, 10, 0);
    chk("ones_const", 32'(outpsum), 32'd57);
    result("ones", 0);

    // all-zeros window: -33
    window("zeros", 3'b000, 5, 5, 5, 2, 10, 0);
    chk("zeros_const", 32'(outpsum), -32'sd33);
    result("zeros", 0);

    // overflow: full value 3317
    window("ovf", 3'b111, 127, 127, 127, 127, 2047, 0);
    chk("ovf_flag_const", 32'(out_overflow), 32'd1);
    result("ovf", 0);

    // downstream backpressure for 5 cycles
    window("bp", 3'b111, 5, 5, 5, 2, 10, 0);
    result("bp", 5);

    // 2-cycle in_valid gaps between beats
    window("gap", 3'b111, 5, 5, 5, 2, 10, 2);
    result("gap", 0);

    // reset after two beats discards the partial window
    beat(3'b000, 50, 50, 50, 100, 1000);
    beat(3'b000, 50, 50, 50, 100, 1000);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_inready", 32'(in_ready), 32'd1);
    window("midrst", 3'b111, 5, 5, 5, 2, 10, 0);
    chk("midrst_const", 32'(outpsum), 32'd57);
    result("midrst", 0);

    // mixed lanes, out_ready held high during accumulation (ignored in ACCUM)
    out_ready = 1'b1;
    window("mixed", 3'b101, 3, -4, 7, -1, 0, 0);
    out_ready = 1'b0;
    chk("mixed_const", 32'(outpsum), 32'd41);
    result("mixed", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
